// File: rtl/mem_stage.sv
// Memory pipeline stage: accepts one EX-side instruction at a time, runs a
// single request/ack data-bus access for loads/stores, and registers the writeback fields.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_stall,
  input  logic        i_RegSrc,
  input  logic [1:0]  i_ResultSrc,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_Result,
  input  logic [31:0] i_Store_Data,
  input  logic [31:0] i_Pc_4,
  input  logic [4:0]  i_Rd,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_valid,
  output logic        o_RegSrc,
  output logic [1:0]  o_ResultSrc,
  output logic [31:0] o_Result,
  output logic [31:0] o_Wb_Data,
  output logic [31:0] o_Pc_4,
  output logic [4:0]  o_Rd,
  output logic        o_misalign,
  output logic        o_bus_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q, pc4_q;
  logic [3:0]    be_q;
  logic [2:0]    f3_q;
  logic [1:0]    rsrc_q;
  logic [4:0]    rd_q;
  logic          we_q, load_q, regsrc_q;

  logic        accept, is_mem, misalign, start_bus, ack_hit, timeout;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign o_stall   = (state_q == S_REQ);
  assign accept    = i_valid & ~o_stall;
  assign is_mem    = i_MemRead | i_MemWrite;
  assign misalign  = is_mem & (((i_Funct3[1:0] == 2'b01) & i_Result[0]) |
                               ((i_Funct3[1:0] == 2'b10) & (i_Result[1:0] != 2'b00)));
  assign start_bus = accept & is_mem & ~misalign;
  assign ack_hit   = (state_q == S_REQ) & i_dmem_ack;
  // Ack wins over a timeout that lands in the same cycle.
  assign timeout   = (state_q == S_REQ) & ~i_dmem_ack & (cnt_q == CW'(ACK_TIMEOUT));

  assign o_dmem_req   = (state_q == S_REQ);
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {addr_q[31:2], 2'b00};
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_be    = be_q;

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = i_Store_Data;
    case (i_Funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << i_Result[1:0];
        wdata_in = {4{i_Store_Data[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << i_Result[1:0];
        wdata_in = {2{i_Store_Data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = i_dmem_rdata[7:0];
    case (addr_q[1:0])
      2'b01:   ld_byte = i_dmem_rdata[15:8];
      2'b10:   ld_byte = i_dmem_rdata[23:16];
      2'b11:   ld_byte = i_dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (start_bus) begin
        state_d = S_REQ;
        cnt_d   = CW'(1);
      end
    end else if (ack_hit | timeout) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc4_q       <= '0;
      be_q        <= '0;
      f3_q        <= '0;
      rsrc_q      <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      load_q      <= 1'b0;
      regsrc_q    <= 1'b0;
      o_valid     <= 1'b0;
      o_RegSrc    <= 1'b0;
      o_ResultSrc <= '0;
      o_Result    <= '0;
      o_Wb_Data   <= '0;
      o_Pc_4      <= '0;
      o_Rd        <= '0;
      o_misalign  <= 1'b0;
      o_bus_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_valid    <= 1'b0;
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
      if (start_bus) begin
        addr_q   <= i_Result;
        wdata_q  <= wdata_in;
        be_q     <= be_in;
        we_q     <= i_MemWrite;
        load_q   <= i_MemRead & ~i_MemWrite;
        f3_q     <= i_Funct3;
        regsrc_q <= i_RegSrc;
        rsrc_q   <= i_ResultSrc;
        pc4_q    <= i_Pc_4;
        rd_q     <= i_Rd;
      end
      if (accept & ~start_bus) begin
        o_valid     <= 1'b1;
        o_RegSrc    <= i_RegSrc & ~misalign;
        o_ResultSrc <= i_ResultSrc;
        o_Result    <= i_Result;
        o_Wb_Data   <= '0;
        o_Pc_4      <= i_Pc_4;
        o_Rd        <= i_Rd;
        o_misalign  <= misalign;
      end else if (ack_hit | timeout) begin
        o_valid     <= 1'b1;
        o_RegSrc    <= regsrc_q & ~timeout;
        o_ResultSrc <= rsrc_q;
        o_Result    <= addr_q;
        o_Wb_Data   <= (ack_hit & load_q) ? ld_data : '0;
        o_Pc_4      <= pc4_q;
        o_Rd        <= rd_q;
        o_bus_err   <= timeout;
      end
    end
  end

endmodule
